// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: word-width helpers, the rounding
// constant and the saturating narrow-down used by the butterfly output stage.
package fft_pkg;

    // Widest intermediate any caller hands to sat_n.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic                    ovf;
        logic signed [SAT_W-1:0] val;
    } sat_t;

    // Full product of two N-bit words.
    function automatic int prod_w(input int n);
        return 2 * n;
    endfunction

    // Rounded twiddle product: one bit of headroom for the add plus one for |W| = 1.0.
    function automatic int t_w(input int n);
        return n + 2;
    endfunction

    // A +/- T before scaling and saturation.
    function automatic int sum_w(input int n);
        return n + 3;
    endfunction

    // Half an LSB of the Q-fraction result, added before the shift for round-half-up.
    function automatic logic signed [SAT_W-1:0] rnd_const(input int q);
        return 64'sd1 <<< (q - 1);
    endfunction

    // Clamp x into the n-bit two's-complement range; ovf flags a clamp.
    function automatic sat_t sat_n(input logic signed [SAT_W-1:0] x, input int n);
        sat_t                    r;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi    = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (n - 1));
        r.ovf = 1'b0;
        r.val = x;
        if (x > hi) begin
            r.ovf = 1'b1;
            r.val = hi;
        end else if (x < lo) begin
            r.ovf = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmul_round.sv
// Complex multiply B*W (or B*conj(W) in inverse mode) over two pipeline
// stages: partial products first, then add/sub and round-half-up to N+2 bits.
module cmul_round
    import fft_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 14
) (
    input  logic                clk,
    input  logic                i_en,
    input  logic                i_inv,
    input  logic signed [N-1:0] i_b_r,
    input  logic signed [N-1:0] i_b_i,
    input  logic signed [N-1:0] i_w_r,
    input  logic signed [N-1:0] i_w_i,
    output logic signed [N+1:0] o_t_r,
    output logic signed [N+1:0] o_t_i
);

    localparam int PROD_W = prod_w(N);
    localparam int T_W    = t_w(N);
    localparam int ACC_W  = PROD_W + 1;
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(rnd_const(Q));

    logic signed [PROD_W-1:0] w_b_r, w_b_i, w_w_r, w_w_i;
    logic signed [PROD_W-1:0] r_brwr_p1, r_biwi_p1, r_brwi_p1, r_biwr_p1;
    logic                     r_inv_p1;
    logic signed [ACC_W-1:0]  w_sum_r, w_sum_i;
    logic signed [T_W-1:0]    w_rnd_r, w_rnd_i;
    logic signed [T_W-1:0]    r_t_r_p2, r_t_i_p2;

    assign w_b_r = PROD_W'(i_b_r);
    assign w_b_i = PROD_W'(i_b_i);
    assign w_w_r = PROD_W'(i_w_r);
    assign w_w_i = PROD_W'(i_w_i);

    // Stage S1: capture the four full-width partial products and the mode bit
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_brwr_p1 <= w_b_r * w_w_r;
            r_biwi_p1 <= w_b_i * w_w_i;
            r_brwi_p1 <= w_b_r * w_w_i;
            r_biwr_p1 <= w_b_i * w_w_r;
            r_inv_p1  <= i_inv;
        end
    end

    // Combine products (conjugating W in inverse mode) and round half-up
    always_comb begin
        w_sum_r = '0;
        w_sum_i = '0;
        if (r_inv_p1) begin
            w_sum_r = ACC_W'(r_brwr_p1) + ACC_W'(r_biwi_p1);
            w_sum_i = ACC_W'(r_biwr_p1) - ACC_W'(r_brwi_p1);
        end else begin
            w_sum_r = ACC_W'(r_brwr_p1) - ACC_W'(r_biwi_p1);
            w_sum_i = ACC_W'(r_brwi_p1) + ACC_W'(r_biwr_p1);
        end
        w_rnd_r = T_W'((w_sum_r + RND) >>> Q);
        w_rnd_i = T_W'((w_sum_i + RND) >>> Q);
    end

    // Stage S2: register the rounded twiddle product T
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_t_r_p2 <= w_rnd_r;
            r_t_i_p2 <= w_rnd_i;
        end
    end

    assign o_t_r = r_t_r_p2;
    assign o_t_i = r_t_i_p2;

endmodule

// File: rtl/butterfly2_pipe.sv
// Radix-2 DIT butterfly X0 = A + W*B, X1 = A - W*B with valid/ready stall,
// forward/inverse mode, optional divide-by-2 and saturating output stage.
module butterfly2_pipe
    import fft_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_inv,
    input  logic                in_scale,
    input  logic signed [N-1:0] in0_r,
    input  logic signed [N-1:0] in0_i,
    input  logic signed [N-1:0] in1_r,
    input  logic signed [N-1:0] in1_i,
    input  logic signed [N-1:0] twiddle_r,
    input  logic signed [N-1:0] twiddle_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out0_r,
    output logic signed [N-1:0] out0_i,
    output logic signed [N-1:0] out1_r,
    output logic signed [N-1:0] out1_i,
    output logic                ovf,
    input  logic                ovf_clr
);

    localparam int T_W   = t_w(N);
    localparam int SUM_W = sum_w(N);

    // Optional halving with round-half-up before saturation.
    function automatic logic signed [SUM_W-1:0] scale_fn(input logic signed [SUM_W-1:0] x,
                                                          input logic s);
        if (s) return (x + SUM_W'(1)) >>> 1;
        return x;
    endfunction

    // Narrow to N bits; MSB of the result is the overflow flag.
    function automatic logic [N:0] sat_fn(input logic signed [SUM_W-1:0] x);
        sat_t s;
        s = sat_n(SAT_W'(x), N);
        return {s.ovf, s.val[N-1:0]};
    endfunction

    logic                   w_en;
    logic                   r_v_p1, r_v_p2, r_v_p3;
    logic signed [N-1:0]    r_a_r_p1, r_a_i_p1, r_a_r_p2, r_a_i_p2;
    logic                   r_scale_p1, r_scale_p2;
    logic signed [T_W-1:0]  w_t_r, w_t_i;
    logic signed [SUM_W-1:0] w_x0_r, w_x0_i, w_x1_r, w_x1_i;
    logic signed [N-1:0]    w_y0_r, w_y0_i, w_y1_r, w_y1_i;
    logic [3:0]             w_sat;
    logic signed [N-1:0]    r_x0_r_p3, r_x0_i_p3, r_x1_r_p3, r_x1_i_p3;
    logic                   r_ovf;

    // The whole pipe advances together; it only stalls when S3 holds an unaccepted beat.
    assign w_en     = ~r_v_p3 | out_ready;
    assign in_ready = w_en;

    cmul_round #(.N(N), .Q(Q)) u_cmul (
        .clk   (clk),
        .i_en  (w_en),
        .i_inv (in_inv),
        .i_b_r (in1_r),
        .i_b_i (in1_i),
        .i_w_r (twiddle_r),
        .i_w_i (twiddle_i),
        .o_t_r (w_t_r),
        .o_t_i (w_t_i)
    );

    // Valid bits shift with the global enable; reset discards in-flight beats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v_p1 <= 1'b0;
            r_v_p2 <= 1'b0;
            r_v_p3 <= 1'b0;
        end else if (w_en) begin
            r_v_p1 <= in_valid;
            r_v_p2 <= r_v_p1;
            r_v_p3 <= r_v_p2;
        end
    end

    // Stages S1/S2: delay A and the scale bit to line up with T
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_a_r_p1   <= in0_r;
            r_a_i_p1   <= in0_i;
            r_scale_p1 <= in_scale;
            r_a_r_p2   <= r_a_r_p1;
            r_a_i_p2   <= r_a_i_p1;
            r_scale_p2 <= r_scale_p1;
        end
    end

    // Sum/difference, optional halving, then saturation of all four components
    always_comb begin
        w_x0_r = scale_fn(SUM_W'(r_a_r_p2) + SUM_W'(w_t_r), r_scale_p2);
        w_x0_i = scale_fn(SUM_W'(r_a_i_p2) + SUM_W'(w_t_i), r_scale_p2);
        w_x1_r = scale_fn(SUM_W'(r_a_r_p2) - SUM_W'(w_t_r), r_scale_p2);
        w_x1_i = scale_fn(SUM_W'(r_a_i_p2) - SUM_W'(w_t_i), r_scale_p2);
        {w_sat[0], w_y0_r} = sat_fn(w_x0_r);
        {w_sat[1], w_y0_i} = sat_fn(w_x0_i);
        {w_sat[2], w_y1_r} = sat_fn(w_x1_r);
        {w_sat[3], w_y1_i} = sat_fn(w_x1_i);
    end

    // Stage S3: output register, loaded only by a valid beat so stalls hold it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0_r_p3 <= '0;
            r_x0_i_p3 <= '0;
            r_x1_r_p3 <= '0;
            r_x1_i_p3 <= '0;
        end else if (w_en && r_v_p2) begin
            r_x0_r_p3 <= w_y0_r;
            r_x0_i_p3 <= w_y0_i;
            r_x1_r_p3 <= w_y1_r;
            r_x1_i_p3 <= w_y1_i;
        end
    end

    // Sticky overflow: a saturating beat entering S3 beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_en && r_v_p2 && (|w_sat)) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign out_valid = r_v_p3;
    assign out0_r    = r_x0_r_p3;
    assign out0_i    = r_x0_i_p3;
    assign out1_r    = r_x1_r_p3;
    assign out1_i    = r_x1_i_p3;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_butterfly2_pipe.sv
// Scoreboard bench for butterfly2_pipe: the driver pushes expected results as
// beats are accepted, a monitor pops and compares whenever a beat leaves.
`timescale 1ns/1ps
module tb_butterfly2_pipe;

    localparam int N = 16;
    localparam int Q = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic in_inv = 1'b0;
    logic in_scale = 1'b0;
    logic signed [N-1:0] in0_r = '0, in0_i = '0, in1_r = '0, in1_i = '0;
    logic signed [N-1:0] twiddle_r = '0, twiddle_i = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [N-1:0] out0_r, out0_i, out1_r, out1_i;
    logic ovf;
    logic ovf_clr = 1'b0;

    typedef struct {
        longint x0r, x0i, x1r, x1i;
        int     acc;
        bit     chk_lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

    butterfly2_pipe #(.N(N), .Q(Q)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_scale  (in_scale),
        .in0_r     (in0_r),
        .in0_i     (in0_i),
        .in1_r     (in1_r),
        .in1_i     (in1_i),
        .twiddle_r (twiddle_r),
        .twiddle_i (twiddle_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0_r    (out0_r),
        .out0_i    (out0_i),
        .out1_r    (out1_r),
        .out1_i    (out1_i),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        case (rdy_mode)
            1:       out_ready = ($urandom_range(0, 1) == 1);
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint clamp16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic longint post(input longint x, input bit sc);
        longint v;
        v = sc ? ((x + 1) >>> 1) : x;
        return clamp16(v);
    endfunction

    // Reference: complex arithmetic on plain integers, rounding half-up to Q bits.
    function automatic exp_t model(input int ar, ai, br, bi, wr, wi, input bit inv, sc);
        exp_t   e;
        longint w_im, tr, ti, half;
        half = longint'(1) << (Q - 1);
        w_im = inv ? -longint'(wi) : longint'(wi);
        tr   = (longint'(br) * wr - longint'(bi) * w_im + half) >>> Q;
        ti   = (longint'(br) * w_im + longint'(bi) * wr + half) >>> Q;
        e.x0r = post(ar + tr, sc);
        e.x0i = post(ai + ti, sc);
        e.x1r = post(ar - tr, sc);
        e.x1i = post(ai - ti, sc);
        e.acc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input longint a, b, c, d);
        exp_t e;
        e.x0r = a; e.x0i = b; e.x1r = c; e.x1i = d;
        e.acc = 0; e.chk_lat = 1'b0;
        return e;
    endfunction

    // Present one beat from the next falling edge until it is accepted.
    task automatic send(input int ar, ai, br, bi, wr, wi, input bit inv, sc, input exp_t e);
        exp_t ex;
        int   tries;
        bit   ok;
        ex = e;
        tries = 0;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in0_r = 16'(ar); in0_i = 16'(ai);
        in1_r = 16'(br); in1_i = 16'(bi);
        twiddle_r = 16'(wr); twiddle_i = 16'(wi);
        in_inv = inv; in_scale = sc;
        while (!ok && tries < 200) begin
            #1;
            if (in_ready && !rst) ok = 1'b1;
            else begin
                tries++;
                @(negedge clk);
            end
        end
        if (ok) begin
            ex.acc = cyc;
            ex.chk_lat = (rdy_mode == 0);
            q.push_back(ex);
        end else begin
            check("accept_timeout", 0, 1);
        end
    endtask

    task automatic send_m(input int ar, ai, br, bi, wr, wi, input bit inv, sc);
        send(ar, ai, br, bi, wr, wi, inv, sc, model(ar, ai, br, bi, wr, wi, inv, sc));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
    endtask

    function automatic int rnd16();
        logic [15:0] t;
        t = 16'($urandom);
        return int'($signed(t));
    endfunction

    function automatic int rndw();
        return int'($urandom_range(0, 32768)) - 16384;
    endfunction

    // Monitor: compare each departing beat and hold-stability across stalls
    initial begin
        exp_t e;
        longint p0r, p0i, p1r, p1i;
        bit prev_stall;
        prev_stall = 1'b0;
        p0r = 0; p0i = 0; p1r = 0; p1i = 0;
        forever begin
            @(negedge clk);
            #1;
            if (prev_stall) begin
                check("hold_x0r", out0_r, p0r);
                check("hold_x0i", out0_i, p0i);
                check("hold_x1r", out1_r, p1r);
                check("hold_x1i", out1_i, p1i);
            end
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("x0r", out0_r, e.x0r);
                    check("x0i", out0_i, e.x0i);
                    check("x1r", out1_r, e.x1r);
                    check("x1i", out1_i, e.x1i);
                    if (e.chk_lat) check("latency", cyc - e.acc, 3);
                end
            end
            prev_stall = !rst && out_valid && !out_ready;
            p0r = out0_r; p0i = out0_i; p1r = out1_r; p1i = out1_i;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_ovf", ovf, 0);
        check("rst_out0_r", out0_r, 0);
        check("rst_out1_i", out1_i, 0);
        @(negedge clk);
        rst = 1'b0;

        // Forward, unity twiddle
        send(1000, 0, 2000, 0, 16384, 0, 0, 0, mk(3000, 0, -1000, 0));
        idle();
        drain();
        check("ovf_after_fwd", ovf, 0);

        // Forward vs inverse with W = -j
        send(1000, 0, 2000, 0, 0, -16384, 0, 0, mk(1000, -2000, 1000, 2000));
        send(1000, 0, 2000, 0, 0, -16384, 1, 0, mk(1000, 2000, 1000, -2000));
        idle();
        drain();

        // Saturation sets sticky ovf
        send(30000, 0, 30000, 0, 16384, 0, 0, 0, mk(32767, 0, 0, 0));
        idle();
        drain();
        check("ovf_set", ovf, 1);
        repeat (2) @(negedge clk);
        #2;
        check("ovf_sticky", ovf, 1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        #2;
        check("ovf_cleared", ovf, 0);

        // Same operands with halving stay in range
        send(30000, 0, 30000, 0, 16384, 0, 0, 1, mk(30000, 0, 0, 0));
        idle();
        drain();
        check("ovf_scaled", ovf, 0);

        // Rounding half-up
        send(0, 0, 1, 0, 8192, 0, 0, 0, mk(1, 0, -1, 0));
        send(3, 0, 0, 0, 16384, 0, 0, 1, mk(2, 0, 2, 0));
        idle();
        drain();

        // Random back-to-back stream, always ready
        for (int k = 0; k < 20; k++)
            send_m(rnd16(), rnd16(), rnd16(), rnd16(), rndw(), rndw(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle();
        drain();

        // Random stream against random backpressure
        #1 rdy_mode = 1;
        for (int k = 0; k < 20; k++)
            send_m(rnd16(), rnd16(), rnd16(), rnd16(), rndw(), rndw(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle();
        drain();
        @(negedge clk);
        #1 rdy_mode = 0;
        repeat (2) @(negedge clk);

        // Reset with three beats in flight behind a stalled output
        #1 rdy_mode = 2;
        for (int k = 0; k < 3; k++)
            send_m(rnd16(), rnd16(), rnd16(), rnd16(), rndw(), rndw(), 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        rdy_mode = 0;
        send(-500, 700, 100, -200, 16384, 0, 0, 0, mk(-400, 500, -600, 900));
        idle();
        drain();
        repeat (10) @(negedge clk);
        #2;
        check("no_stale_left", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
